// File: rtl/wb_stage.sv
// Writeback stage of the 5-stage LC-3b pipeline.
// Holds the MEM/WB pipeline register, drives the register-file write port,
// maintains the NZP condition codes and counts retired instructions.
// A stalled memory stage hands WB a bubble; WB never holds or replays a write.
module wb_stage #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_stall,
  input  logic                 flush,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     alu_in,
  input  logic [WIDTH-1:0]     mdr_in,
  input  logic [WIDTH-1:0]     ir_in,
  input  logic [WIDTH-1:0]     pc_in,
  input  logic                 load_regfile_in,
  input  logic                 load_cc_in,
  input  logic                 dest_r7_in,
  input  logic [1:0]           wbmux_sel_in,
  output logic                 regfile_we,
  output logic [2:0]           regfile_dest,
  output logic [WIDTH-1:0]     regfile_data,
  output logic [2:0]           nzp,
  output logic                 fwd_valid,
  output logic [CNT_WIDTH-1:0] retire_count
);

  // Writeback source encodings.
  localparam logic [1:0] WbSelAlu = 2'b00;
  localparam logic [1:0] WbSelMdr = 2'b01;
  localparam logic [1:0] WbSelPc  = 2'b10;

  // NZP value after reset: "zero".
  localparam logic [2:0] NzpReset = 3'b010;

  // MEM/WB pipeline register.
  logic             stValid;
  logic [WIDTH-1:0] stAlu;
  logic [WIDTH-1:0] stMdr;
  logic [WIDTH-1:0] stIr;
  logic [WIDTH-1:0] stPc;
  logic             stLoadRegfile;
  logic             stLoadCc;
  logic             stDestR7;
  logic [1:0]       stWbmuxSel;

  logic [WIDTH-1:0] wbData;
  logic             bubble;

  // Only IR[11:9] (the DR field) is consumed here; the rest rides along.
  logic unusedIr;
  assign unusedIr = ^{stIr[15:12], stIr[8:0]};

  // A stalled or squashed MEM stage delivers nothing this cycle.
  assign bubble = flush | mem_stall;

  // Pipeline register: reset, then bubble, then normal capture.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      stValid       <= 1'b0;
      stAlu         <= '0;
      stMdr         <= '0;
      stIr          <= '0;
      stPc          <= '0;
      stLoadRegfile <= 1'b0;
      stLoadCc      <= 1'b0;
      stDestR7      <= 1'b0;
      stWbmuxSel    <= WbSelAlu;
    end else begin
      stValid       <= valid_in;
      stAlu         <= alu_in;
      stMdr         <= mdr_in;
      stIr          <= ir_in;
      stPc          <= pc_in;
      stLoadRegfile <= load_regfile_in;
      stLoadCc      <= load_cc_in;
      stDestR7      <= dest_r7_in;
      stWbmuxSel    <= wbmux_sel_in;
    end
  end

  // Writeback source mux; select 11 is reserved and drives zero.
  // NOTE: the default assignment ahead of the case keeps this purely
  // combinational for every select value (no inferred latch).
  always_comb begin
    wbData = '0;
    case (stWbmuxSel)
      WbSelAlu: wbData = stAlu;
      WbSelMdr: wbData = stMdr;
      WbSelPc:  wbData = stPc;
      default:  wbData = '0;
    endcase
  end

  assign regfile_data = wbData;
  assign regfile_dest = stDestR7 ? 3'd7 : stIr[11:9];
  assign regfile_we   = stValid & stLoadRegfile;
  assign fwd_valid    = regfile_we;

  // Condition codes follow the value being written; exactly one bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      nzp <= NzpReset;
    end else if (stValid && stLoadCc) begin
      nzp <= {wbData[WIDTH-1],
              wbData == '0,
              !wbData[WIDTH-1] && (wbData != '0)};
    end
  end

  // Retired-instruction counter; wraps silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_count <= '0;
    end else if (stValid) begin
      retire_count <= retire_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_stall;
  logic        flush;
  logic        valid_in;
  logic [15:0] alu_in;
  logic [15:0] mdr_in;
  logic [15:0] ir_in;
  logic [15:0] pc_in;
  logic        load_regfile_in;
  logic        load_cc_in;
  logic        dest_r7_in;
  logic [1:0]  wbmux_sel_in;
  logic        regfile_we;
  logic [2:0]  regfile_dest;
  logic [15:0] regfile_data;
  logic [2:0]  nzp;
  logic        fwd_valid;
  logic [15:0] retire_count;

  wb_stage #(.WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_stall       (mem_stall),
    .flush           (flush),
    .valid_in        (valid_in),
    .alu_in          (alu_in),
    .mdr_in          (mdr_in),
    .ir_in           (ir_in),
    .pc_in           (pc_in),
    .load_regfile_in (load_regfile_in),
    .load_cc_in      (load_cc_in),
    .dest_r7_in      (dest_r7_in),
    .wbmux_sel_in    (wbmux_sel_in),
    .regfile_we      (regfile_we),
    .regfile_dest    (regfile_dest),
    .regfile_data    (regfile_data),
    .nzp             (nzp),
    .fwd_valid       (fwd_valid),
    .retire_count    (retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] mdr;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        loadRegfile;
    logic        loadCc;
    logic        destR7;
    logic [1:0]  sel;
  } instT;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: the instruction currently presented to the register
  // file (empty means bubble), the architectural NZP and the retire count.
  instT        inWb;
  logic [2:0]  refNzp;
  logic [15:0] refCount;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] resultOf(input instT t);
    case (t.sel)
      2'b00:   return t.alu;
      2'b01:   return t.mdr;
      2'b10:   return t.pc;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [2:0] ccOf(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0000)  return 3'b010;
    return 3'b001;
  endfunction

  function automatic instT randInst();
    instT t;
    t.valid       = 1'($urandom);
    t.alu         = 16'($urandom);
    t.mdr         = 16'($urandom);
    t.ir          = 16'($urandom);
    t.pc          = 16'($urandom);
    t.loadRegfile = 1'($urandom);
    t.loadCc      = 1'($urandom);
    t.destR7      = ($urandom_range(0, 3) == 0);
    t.sel         = 2'($urandom);
    return t;
  endfunction

  function automatic instT mkInst(input logic [1:0] sel, input logic [15:0] val,
                                  input logic [2:0] dr, input logic lr,
                                  input logic lc, input logic r7);
    instT t;
    t             = '0;
    t.valid       = 1'b1;
    t.sel         = sel;
    t.alu         = (sel == 2'b00) ? val : 16'h1111;
    t.mdr         = (sel == 2'b01) ? val : 16'h2222;
    t.pc          = (sel == 2'b10) ? val : 16'h3333;
    t.ir          = {4'h1, dr, 9'h0A5};
    t.loadRegfile = lr;
    t.loadCc      = lc;
    t.destR7      = r7;
    return t;
  endfunction

  // Compare every observable output against the model.
  task automatic checkAll(input string tag);
    logic       expWe;
    logic [2:0] expDest;
    expWe   = inWb.valid && inWb.loadRegfile;
    expDest = inWb.destR7 ? 3'd7 : inWb.ir[11:9];
    check({tag, ".we"},    32'(regfile_we),   32'(expWe));
    check({tag, ".fwd"},   32'(fwd_valid),    32'(expWe));
    check({tag, ".dest"},  32'(regfile_dest), 32'(expDest));
    check({tag, ".data"},  32'(regfile_data), 32'(resultOf(inWb)));
    check({tag, ".nzp"},   32'(nzp),          32'(refNzp));
    check({tag, ".count"}, 32'(retire_count), 32'(refCount));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then
  // (optionally) compare outputs 1 time unit after the edge.
  task automatic step(input instT t, input logic rst, input logic stall,
                      input logic fl, input logic doCheck, input string tag);
    reset           = rst;
    mem_stall       = stall;
    flush           = fl;
    valid_in        = t.valid;
    alu_in          = t.alu;
    mdr_in          = t.mdr;
    ir_in           = t.ir;
    pc_in           = t.pc;
    load_regfile_in = t.loadRegfile;
    load_cc_in      = t.loadCc;
    dest_r7_in      = t.destR7;
    wbmux_sel_in    = t.sel;
    @(posedge clk);
    if (rst) begin
      inWb     = '0;
      refNzp   = 3'b010;
      refCount = 16'd0;
    end else begin
      if (inWb.valid) begin
        refCount = refCount + 16'd1;
        if (inWb.loadCc) refNzp = ccOf(resultOf(inWb));
      end
      inWb = (stall || fl) ? instT'('0) : t;
    end
    #1;
    if (doCheck) checkAll(tag);
  endtask

  initial begin
    instT t;
    inWb     = '0;
    refNzp   = 3'b010;
    refCount = 16'd0;

    // Reset for two cycles with arbitrary inputs.
    for (int i = 0; i < 2; i++) step(randInst(), 1'b1, 1'($urandom), 1'($urandom), 1'b1, "reset");
    check("reset.we_const",  32'(regfile_we),   32'd0);
    check("reset.nzp_const", 32'(nzp),          32'h2);
    check("reset.cnt_const", 32'(retire_count), 32'd0);

    // ALU writeback of a negative value to R3.
    step(mkInst(2'b00, 16'h8001, 3'd3, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, "alu");
    check("alu.we_const",   32'(regfile_we),   32'd1);
    check("alu.dest_const", 32'(regfile_dest), 32'd3);
    check("alu.data_const", 32'(regfile_data), 32'h8001);

    // LDR of zero (sets Z), then JSR linking PC into R7 without touching NZP.
    step(mkInst(2'b01, 16'h0000, 3'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, "ldr");
    check("alu.nzp_const", 32'(nzp),          32'h4);
    check("alu.cnt_const", 32'(retire_count), 32'd1);
    check("ldr.data_const", 32'(regfile_data), 32'h0000);
    step(mkInst(2'b10, 16'h3002, 3'd1, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0, 1'b1, "jsr");
    check("ldr.nzp_const",  32'(nzp),          32'h2);
    check("jsr.dest_const", 32'(regfile_dest), 32'd7);
    check("jsr.data_const", 32'(regfile_data), 32'h3002);
    step(mkInst(2'b00, 16'h0001, 3'd2, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, "idle");
    check("jsr.nzp_const", 32'(nzp), 32'h2);

    // Three stall cycles with a valid instruction waiting, then release.
    t = mkInst(2'b00, 16'h0042, 3'd4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(t, 1'b0, 1'b1, 1'b0, 1'b1, "stall");
      check("stall.we_const", 32'(regfile_we), 32'd0);
    end
    step(t, 1'b0, 1'b0, 1'b0, 1'b1, "release");
    check("release.we_const", 32'(regfile_we), 32'd1);
    t.valid = 1'b0;
    step(t, 1'b0, 1'b0, 1'b0, 1'b1, "release_after");
    check("release.we_once", 32'(regfile_we), 32'd0);

    // Flush alone, then flush together with stall; valid-less write request.
    step(mkInst(2'b00, 16'hFFFF, 3'd6, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b1, 1'b1, "flush");
    step(mkInst(2'b00, 16'hFFFF, 3'd6, 1'b1, 1'b1, 1'b0), 1'b0, 1'b1, 1'b1, 1'b1, "flush_stall");
    t = mkInst(2'b00, 16'h8000, 3'd6, 1'b1, 1'b1, 1'b0);
    t.valid = 1'b0;
    step(t, 1'b0, 1'b0, 1'b0, 1'b1, "invalid_req");
    step(randInst(), 1'b0, 1'b1, 1'b0, 1'b1, "post_flush");
    check("flush.nzp_const", 32'(nzp), 32'h1);

    // Back-to-back writes to the same register.
    step(mkInst(2'b00, 16'h0010, 3'd2, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, "b2b0");
    step(mkInst(2'b01, 16'h0020, 3'd2, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, "b2b1");
    check("b2b.first_we", 32'(regfile_we), 32'd1);

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step(randInst(), ($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), 1'b1, "rand");
    end

    // Reset while a valid write sits in the stage.
    step(mkInst(2'b00, 16'h7FFF, 3'd1, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0, 1'b1, "pre_rst");
    check("pre_rst.we_const", 32'(regfile_we), 32'd1);
    step(mkInst(2'b00, 16'h8000, 3'd1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0, 1'b1, "mid_rst");
    check("mid_rst.we_const",  32'(regfile_we),   32'd0);
    check("mid_rst.nzp_const", 32'(nzp),          32'h2);
    check("mid_rst.cnt_const", 32'(retire_count), 32'd0);

    // Counter wrap: stream valid instructions until the count reaches FFFF.
    t = mkInst(2'b00, 16'h0005, 3'd0, 1'b0, 1'b0, 1'b0);
    while (refCount != 16'hFFFF) step(t, 1'b0, 1'b0, 1'b0, 1'b0, "fill");
    checkAll("wrap_pre");
    check("wrap.pre_const", 32'(retire_count), 32'h0000FFFF);
    step(t, 1'b0, 1'b0, 1'b0, 1'b1, "wrap");
    check("wrap.zero_const", 32'(retire_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
